// File: rtl/snake_pkg.sv
// Shared encodings for the snake game control blocks: game states, move directions.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package snake_pkg;

    // game_state encodings driven by the game controller
    localparam logic [1:0] RUNNING = 2'b00;
    localparam logic [1:0] DIE     = 2'b01;
    localparam logic [1:0] INITIAL = 2'b10;

    // move direction encodings
    localparam logic [1:0] UP    = 2'b00;
    localparam logic [1:0] DOWN  = 2'b01;
    localparam logic [1:0] LEFT  = 2'b10;
    localparam logic [1:0] RIGHT = 2'b11;

    localparam logic [3:0] SPEED_MAX = 4'd15;

    // Opposite pairs differ only in bit 0 (up/down, left/right).
    function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
        return {dir[1], ~dir[0]};
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Two-entry direction queue buffering turns that arrive between move ticks.
// Latency: push visible at head/tail the cycle after; pop takes effect the cycle after.
// Backpressure: a push while full is dropped (contents unchanged); a pop while empty is ignored.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             empties the queue (wins over push/pop)
//   push, push_dat    enqueue a direction at the tail
//   pop               dequeue the head
//   full, empty       occupancy flags
//   head, tail        oldest / newest entry (tail == head with one entry)
module dir_fifo
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic [1:0] push_dat,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [1:0] head,
    output logic [1:0] tail
);

    logic [1:0] ent0_q, ent0_d;   // head slot
    logic [1:0] ent1_q, ent1_d;   // second slot
    logic [1:0] cnt_q,  cnt_d;    // 0..2

    logic push_ok;
    logic pop_ok;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign head    = ent0_q;
    assign tail    = full ? ent1_q : ent0_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (empty) begin
                        ent0_d = push_dat;
                    end else begin
                        ent1_d = push_dat;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Only reachable with exactly one entry (push_ok needs !full,
                    // pop_ok needs !empty): the new entry replaces the popped head.
                    ent0_d = push_dat;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0_q <= RIGHT;
            ent1_q <= RIGHT;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Snake move scheduler: turns button edges into queued turns and issues timed move requests.
// Latency: move_req rises the cycle after the tick (counter == period-1); a button edge is queued the cycle after it is seen.
// Backpressure: move_req/move_ack handshake; a tick while a request is pending sets sticky overrun and is otherwise skipped.
//
// Optional feature macro: MOVE_SPEEDUP_EN (food-driven speed levels shorten the move period).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   game_state[1:0]            00 RUNNING, 01 DIE, 10 INITIAL
//   up, down, left, right      debounced level buttons
//   food_eaten                 single-cycle pulse
//   move_ack                   body datapath accepted the pending move
//   move_req, move_dir[1:0]    move request and its direction (stable while move_req)
//   speed_level[3:0]           current speed level
//   overrun                    sticky: a tick fired while move_req was pending
module move_scheduler
    import snake_pkg::*;
#(
    parameter int unsigned TICK_BASE = 12_500_000,
    parameter int unsigned TICK_STEP = 500_000,
    parameter int unsigned TICK_MIN  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] game_state,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       food_eaten,
    input  logic       move_ack,
    output logic       move_req,
    output logic [1:0] move_dir,
    output logic [3:0] speed_level,
    output logic       overrun
);

`ifdef MOVE_SPEEDUP_EN
    // max(TICK_BASE - lvl*TICK_STEP, TICK_MIN) without unsigned underflow.
    function automatic logic [31:0] calc_period(input logic [3:0] lvl);
        logic [31:0] red;
        red = 32'(lvl) * 32'(TICK_STEP);
        if (red >= 32'(TICK_BASE)) begin
            return 32'(TICK_MIN);
        end else if ((32'(TICK_BASE) - red) < 32'(TICK_MIN)) begin
            return 32'(TICK_MIN);
        end else begin
            return 32'(TICK_BASE) - red;
        end
    endfunction
`else
    // food_eaten has no effect when the speed-up feature is compiled out.
    logic unused_food_eaten;
    assign unused_food_eaten = food_eaten;
`endif

    // Button edge detection, bit order {up, down, left, right}.
    logic [3:0] btn_q, btn_d;
    logic [3:0] btn_rise;

    logic       cand_vld;
    logic [1:0] cand_dir;

    logic [1:0]  cur_dir_q,  cur_dir_d;
    logic        move_req_q, move_req_d;
    logic [3:0]  speed_q,    speed_d;
    logic        overrun_q,  overrun_d;
    logic [31:0] cnt_q,      cnt_d;
    // Period in force for the current counter lap; reloaded only at a wrap
    // so a speed change never shortens a lap that is already under way.
    logic [31:0] period_q,   period_d;
    logic [31:0] period_next;
    // Remembers INITIAL from the previous cycle, so cur_dir is forced to
    // RIGHT only on entry and a direction chosen in INITIAL is then held.
    logic        was_init_q, was_init_d;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_flush;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  fifo_head;
    logic [1:0]  fifo_tail;

    logic [1:0]  ref_dir;
    logic        tick;
    logic        is_running;

    assign btn_d    = {up, down, left, right};
    assign btn_rise = btn_d & ~btn_q;

    // One candidate per cycle; fixed priority up > down > left > right.
    always_comb begin
        cand_vld = 1'b1;
        cand_dir = RIGHT;
        if (btn_rise[3]) begin
            cand_dir = UP;
        end else if (btn_rise[2]) begin
            cand_dir = DOWN;
        end else if (btn_rise[1]) begin
            cand_dir = LEFT;
        end else if (btn_rise[0]) begin
            cand_dir = RIGHT;
        end else begin
            cand_vld = 1'b0;
        end
    end

    // Turns are validated against the last direction the snake will have
    // taken once queued turns drain, not against the current heading.
    assign ref_dir    = fifo_empty ? cur_dir_q : fifo_tail;
    assign is_running = (game_state == RUNNING);
    assign tick       = is_running && (cnt_q == (period_q - 32'd1));
    assign was_init_d = (game_state == INITIAL);

    always_comb begin
        cur_dir_d   = cur_dir_q;
        move_req_d  = move_req_q;
        speed_d     = speed_q;
        overrun_d   = overrun_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        period_next = 32'(TICK_BASE);

        case (game_state)
            RUNNING: begin
                cnt_d = tick ? 32'd0 : cnt_q + 32'd1;

                if (cand_vld && (cand_dir != ref_dir) &&
                    (cand_dir != opposite_dir(ref_dir))) begin
                    fifo_push = 1'b1;
                end

                if (move_req_q) begin
                    // Pending request: a tick is recorded as an overrun and
                    // the queue is left alone so no turn is lost.
                    if (tick) begin
                        overrun_d = 1'b1;
                    end
                    if (move_ack) begin
                        move_req_d = 1'b0;
                    end
                end else if (tick) begin
                    move_req_d = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        cur_dir_d = fifo_head;
                    end
                end

`ifdef MOVE_SPEEDUP_EN
                if (food_eaten && (speed_q != SPEED_MAX)) begin
                    speed_d = speed_q + 4'd1;
                end
                period_next = calc_period(speed_d);
`endif
                if (tick) begin
                    period_d = period_next;
                end
            end

            INITIAL: begin
                fifo_flush = 1'b1;
                speed_d    = 4'd0;
                overrun_d  = 1'b0;
                move_req_d = 1'b0;
                cnt_d      = 32'd0;
`ifdef MOVE_SPEEDUP_EN
                period_next = calc_period(4'd0);
`endif
                period_d   = period_next;
                if (cand_vld) begin
                    cur_dir_d = cand_dir;
                end else if (!was_init_q) begin
                    cur_dir_d = RIGHT;
                end
            end

            default: begin
                // DIE (and the unused encoding): freeze direction, queue and
                // speed; drop any pending request and restart the lap.
                move_req_d = 1'b0;
                cnt_d      = 32'd0;
            end
        endcase
    end

    dir_fifo u_dir_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (fifo_flush),
        .push     (fifo_push),
        .push_dat (cand_dir),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head),
        .tail     (fifo_tail)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q      <= 4'd0;
            cur_dir_q  <= RIGHT;
            move_req_q <= 1'b0;
            speed_q    <= 4'd0;
            overrun_q  <= 1'b0;
            cnt_q      <= 32'd0;
            period_q   <= 32'(TICK_BASE);
            was_init_q <= 1'b0;
        end else begin
            btn_q      <= btn_d;
            cur_dir_q  <= cur_dir_d;
            move_req_q <= move_req_d;
            speed_q    <= speed_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            was_init_q <= was_init_d;
        end
    end

    // cur_dir only changes on a pop, which coincides with move_req rising,
    // so move_dir is stable for the whole handshake.
    assign move_req    = move_req_q;
    assign move_dir    = cur_dir_q;
    assign speed_level = speed_q;
    assign overrun     = overrun_q;

endmodule
